rv_lsu: RTL and testbench
=========================

// Module: rv_lsu
// PURPOSE
//  Load/store unit: consumes mem_read/mem_write/funct3 from the decoded instruction and drives a
//  req/gnt/rvalid data-memory bus. Handles byte enables, lane steering, load sign/zero-extension,
//  misalignment checks and bus timeout. Stalls the pipeline while an access is outstanding.
// PARAMETERS
//  TIMEOUT   256  cycles allowed in REQ+WAIT before bus-timeout fault; 0 disables the check
// PORTS
//  clk            in   1   clock, all state updates on rising edge
//  rstn           in   1   reset, synchronous, active-low
//  mem_read_i     in   1   load request from the current instruction
//  mem_write_i    in   1   store request from the current instruction
//  funct3_i       in   3   access size/sign (LB/LH/LW/LBU/LHU, SB/SH/SW)
//  addr_i         in   32  effective byte address (ALU result)
//  wdata_i        in   32  store data (rs2)
//  stall_o        out  1   hold pipeline
//  load_valid_o   out  1   1-cycle pulse: load_data_o valid
//  load_data_o    out  32  extended load result
//  exc_o          out  1   1-cycle fault pulse
//  exc_cause_o    out  2   01 misaligned, 10 illegal access, 11 bus timeout
//  dmem_req_o     out  1   bus request
//  dmem_we_o      out  1   1 store, 0 load
//  dmem_addr_o    out  32  word address, {addr[31:2],2'b00}
//  dmem_be_o      out  4   byte enables
//  dmem_wdata_o   out  32  lane-steered store data
//  dmem_gnt_i     in   1   request accepted this cycle
//  dmem_rvalid_i  in   1   read data valid
//  dmem_rdata_i   in   32  read data word
// BEHAVIOUR
//  Reset (rstn=0 at clk edge): state=IDLE, timeout counter=0; all outputs 0.
//  States: IDLE, REQ, WAIT, DONE.
//  IDLE: access = mem_read_i|mem_write_i. Checks on access:
//   - both read and write set, or funct3 not in {000,001,010,100,101} (load) / {000,001,010}
//     (store) -> exc_o=1, cause=10, stay IDLE, no bus request, stall_o=0.
//   - half with addr[0]=1, or word with addr[1:0]!=0 -> exc_o=1, cause=01, stay IDLE, no bus req.
//   - otherwise: latch addr/funct3/we/wdata, stall_o=1 combinationally this cycle, go REQ.
//  REQ: dmem_req_o=1; addr/we/be/wdata held stable from latched values until gnt.
//   On dmem_gnt_i: store -> DONE; load -> WAIT. stall_o=1.
//  WAIT: stall_o=1; dmem_rvalid_i only honoured in WAIT (rvalid earliest 1 cycle after gnt).
//   On rvalid: capture extended data -> DONE.
//  DONE: stall_o=0; load_valid_o=1 for loads only; next state IDLE. Exactly one cycle.
//  Timeout: counter clears on entering REQ, increments each cycle in REQ/WAIT; when it reaches
//   TIMEOUT (TIMEOUT!=0): drop dmem_req_o, exc_o=1 cause=11 in DONE, no load_valid_o.
//  Byte enables: B -> 4'b0001<<addr[1:0]; H -> 4'b0011<<{addr[1],1'b0}; W -> 4'b1111.
//  Store data: SB replicates wdata[7:0] to all lanes; SH replicates wdata[15:0]; SW as-is.
//  Load: selected lane shifted to bit 0; LB/LH sign-extend, LBU/LHU zero-extend, LW unchanged.
//  load_data_o holds last value until next load completes.
//  Min latency: store 2 cycles (IDLE->REQ w/ gnt->DONE); load 3 cycles with rvalid 1 cycle after gnt.
//  rstn=0 mid-access: abandon access, drop dmem_req_o next edge, no exc/valid pulse.
// TESTING
//  SW addr=0x100 wdata=0xDEADBEEF, gnt same cycle -> req 1 cycle, be=1111, addr=0x100, DONE
//   next cycle, stall_o low there.
//  LB addr=0x203, rdata=0x80FFFFFF -> be=1000, load_data_o=0xFFFFFF80; LBU -> 0x00000080.
//  SH addr=0x12 wdata=0x0000ABCD -> be=1100, dmem_wdata_o=0xABCDABCD; LH addr=0x11 -> exc cause 01,
//   no req.
//  gnt withheld 5 cycles -> req/addr/be stable all 5 cycles, stall_o high throughout, then normal.
//  TIMEOUT=8, never gnt -> exc_o pulse cause 11 after 8 cycles, req drops, no load_valid_o.
//  Load in WAIT, rstn=0 one cycle -> all outputs 0, state IDLE, later rvalid ignored.

Source files
------------

// File: rtl/rv_lsu.sv
// Load/store unit: turns decoded load/store requests into req/gnt/rvalid bus cycles with lane steering.
// Latency: store 2 cycles (IDLE, REQ+gnt), load 3 cycles minimum (IDLE, REQ+gnt, WAIT+rvalid), then one DONE cycle.
// Backpressure: holds stall_o while the bus withholds gnt/rvalid; a bus timeout aborts the access with a fault.
module rv_lsu #(
  parameter int TIMEOUT = 256
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        mem_read_i,
  input  logic        mem_write_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        stall_o,
  output logic        load_valid_o,
  output logic [31:0] load_data_o,
  output logic        exc_o,
  output logic [1:0]  exc_cause_o,
  output logic        dmem_req_o,
  output logic        dmem_we_o,
  output logic [31:0] dmem_addr_o,
  output logic [3:0]  dmem_be_o,
  output logic [31:0] dmem_wdata_o,
  input  logic        dmem_gnt_i,
  input  logic        dmem_rvalid_i,
  input  logic [31:0] dmem_rdata_i
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  // Counter is wide enough to hold TIMEOUT itself.
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  state_t        state_q, state_d;
  logic [31:0]   addr_q, addr_d;
  logic [2:0]    funct3_q, funct3_d;
  logic          we_q, we_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          fault_q, fault_d;
  logic [31:0]   load_data_q, load_data_d;

  logic          access, illegal, misal, timed_out;
  logic [CW-1:0] cnt_inc;
  logic [3:0]    be_w;
  logic [31:0]   wdata_w, lane_w, ext_w;

  // Access decode for the incoming instruction and lane steering for the latched one.
  always_comb begin
    access  = rstn & (mem_read_i | mem_write_i);
    illegal = (mem_read_i & mem_write_i)
            | (mem_read_i & ~(funct3_i inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101}))
            | (mem_write_i & ~(funct3_i inside {3'b000, 3'b001, 3'b010}));
    misal   = ((funct3_i[1:0] == 2'b01) & addr_i[0])
            | ((funct3_i[1:0] == 2'b10) & (addr_i[1:0] != 2'b00));

    cnt_inc   = cnt_q + CW'(1);
    timed_out = (TIMEOUT != 0) && (cnt_inc == CW'(TIMEOUT));

    case (funct3_q[1:0])
      2'b00:   be_w = 4'b0001 << addr_q[1:0];
      2'b01:   be_w = 4'b0011 << {addr_q[1], 1'b0};
      default: be_w = 4'b1111;
    endcase
    case (funct3_q[1:0])
      2'b00:   wdata_w = {4{wdata_q[7:0]}};
      2'b01:   wdata_w = {2{wdata_q[15:0]}};
      default: wdata_w = wdata_q;
    endcase

    lane_w = dmem_rdata_i >> {addr_q[1:0], 3'b000};
    case (funct3_q)
      3'b000:  ext_w = {{24{lane_w[7]}}, lane_w[7:0]};
      3'b001:  ext_w = {{16{lane_w[15]}}, lane_w[15:0]};
      3'b100:  ext_w = {24'd0, lane_w[7:0]};
      3'b101:  ext_w = {16'd0, lane_w[15:0]};
      default: ext_w = lane_w;
    endcase
  end

  // Next-state and output logic of the access FSM.
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    funct3_d     = funct3_q;
    we_d         = we_q;
    wdata_d      = wdata_q;
    cnt_d        = cnt_q;
    fault_d      = fault_q;
    load_data_d  = load_data_q;
    stall_o      = 1'b0;
    load_valid_o = 1'b0;
    exc_o        = 1'b0;
    exc_cause_o  = 2'b00;
    dmem_req_o   = 1'b0;
    dmem_we_o    = 1'b0;
    dmem_addr_o  = 32'd0;
    dmem_be_o    = 4'd0;
    dmem_wdata_o = 32'd0;

    case (state_q)
      IDLE: begin
        if (access) begin
          if (illegal) begin
            exc_o       = 1'b1;
            exc_cause_o = 2'b10;
          end else if (misal) begin
            exc_o       = 1'b1;
            exc_cause_o = 2'b01;
          end else begin
            stall_o  = 1'b1;
            addr_d   = addr_i;
            funct3_d = funct3_i;
            we_d     = mem_write_i;
            wdata_d  = wdata_i;
            cnt_d    = '0;
            fault_d  = 1'b0;
            state_d  = REQ;
          end
        end
      end
      REQ: begin
        stall_o      = 1'b1;
        dmem_req_o   = 1'b1;
        dmem_we_o    = we_q;
        dmem_addr_o  = {addr_q[31:2], 2'b00};
        dmem_be_o    = be_w;
        dmem_wdata_o = wdata_w;
        cnt_d        = cnt_inc;
        // A grant on the final allowed cycle still wins over the timeout.
        if (dmem_gnt_i) begin
          state_d = we_q ? DONE : WAIT;
        end else if (timed_out) begin
          fault_d = 1'b1;
          state_d = DONE;
        end
      end
      WAIT: begin
        stall_o = 1'b1;
        cnt_d   = cnt_inc;
        if (dmem_rvalid_i) begin
          load_data_d = ext_w;
          state_d     = DONE;
        end else if (timed_out) begin
          fault_d = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        exc_o        = fault_q;
        exc_cause_o  = fault_q ? 2'b11 : 2'b00;
        load_valid_o = ~we_q & ~fault_q;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign load_data_o = load_data_q;

  // State registers; reset abandons any access in flight.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      funct3_q    <= '0;
      we_q        <= 1'b0;
      wdata_q     <= '0;
      cnt_q       <= '0;
      fault_q     <= 1'b0;
      load_data_q <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      funct3_q    <= funct3_d;
      we_q        <= we_d;
      wdata_q     <= wdata_d;
      cnt_q       <= cnt_d;
      fault_q     <= fault_d;
      load_data_q <= load_data_d;
    end
  end

endmodule

// File: tb/tb_rv_lsu.sv
// Directed bench for rv_lsu with a load-result scoreboard.
// Inputs change 1 time unit after the rising edge; outputs are sampled 1 unit later.
// Waits for DUT results are bounded by a cycle budget.
module tb_rv_lsu;

  logic        clk = 1'b0;
  logic        rstn;
  logic        mem_read_i, mem_write_i;
  logic [2:0]  funct3_i;
  logic [31:0] addr_i, wdata_i;
  logic        stall_o, load_valid_o, exc_o;
  logic [31:0] load_data_o;
  logic [1:0]  exc_cause_o;
  logic        dmem_req_o, dmem_we_o;
  logic [31:0] dmem_addr_o, dmem_wdata_o;
  logic [3:0]  dmem_be_o;
  logic        dmem_gnt_i, dmem_rvalid_i;
  logic [31:0] dmem_rdata_i;

  int n_assert = 0;
  int n_fail   = 0;
  logic [31:0] exp_q[$];

  rv_lsu #(.TIMEOUT(8)) dut (
    .clk(clk), .rstn(rstn),
    .mem_read_i(mem_read_i), .mem_write_i(mem_write_i), .funct3_i(funct3_i),
    .addr_i(addr_i), .wdata_i(wdata_i),
    .stall_o(stall_o), .load_valid_o(load_valid_o), .load_data_o(load_data_o),
    .exc_o(exc_o), .exc_cause_o(exc_cause_o),
    .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o), .dmem_addr_o(dmem_addr_o),
    .dmem_be_o(dmem_be_o), .dmem_wdata_o(dmem_wdata_o),
    .dmem_gnt_i(dmem_gnt_i), .dmem_rvalid_i(dmem_rvalid_i), .dmem_rdata_i(dmem_rdata_i)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic rd, input logic wr, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd);
    mem_read_i  = rd;
    mem_write_i = wr;
    funct3_i    = f3;
    addr_i      = a;
    wdata_i     = wd;
  endtask

  task automatic idle_inputs();
    drive(1'b0, 1'b0, 3'b000, 32'd0, 32'd0);
  endtask

  // Store: optional grant delay, checks bus fields stable while waiting for gnt.
  task automatic do_store(input string tag, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, input logic [3:0] ebe,
                          input logic [31:0] ewd, input int gnt_delay);
    drive(1'b0, 1'b1, f3, a, wd);
    #1;
    chk({tag, "_idle_stall"}, 32'(stall_o), 32'd1);
    tick();
    idle_inputs();
    for (int i = 0; i <= gnt_delay; i++) begin
      dmem_gnt_i = (i == gnt_delay);
      #1;
      chk({tag, "_req"},   32'(dmem_req_o), 32'd1);
      chk({tag, "_we"},    32'(dmem_we_o), 32'd1);
      chk({tag, "_addr"},  dmem_addr_o, {a[31:2], 2'b00});
      chk({tag, "_be"},    32'(dmem_be_o), 32'(ebe));
      chk({tag, "_wdata"}, dmem_wdata_o, ewd);
      chk({tag, "_stall"}, 32'(stall_o), 32'd1);
      tick();
    end
    dmem_gnt_i = 1'b0;
    #1;
    chk({tag, "_done_stall"}, 32'(stall_o), 32'd0);
    chk({tag, "_done_req"},   32'(dmem_req_o), 32'd0);
    chk({tag, "_done_lv"},    32'(load_valid_o), 32'd0);
    chk({tag, "_done_exc"},   32'(exc_o), 32'd0);
    tick();
  endtask

  // Load: gnt in first REQ cycle, rvalid one cycle later; result checked via scoreboard.
  task automatic do_load(input string tag, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] rdata, input logic [3:0] ebe,
                         input logic [31:0] expv);
    int waited;
    exp_q.push_back(expv);
    drive(1'b1, 1'b0, f3, a, 32'd0);
    tick();
    idle_inputs();
    dmem_gnt_i = 1'b1;
    #1;
    chk({tag, "_req"},  32'(dmem_req_o), 32'd1);
    chk({tag, "_we"},   32'(dmem_we_o), 32'd0);
    chk({tag, "_addr"}, dmem_addr_o, {a[31:2], 2'b00});
    chk({tag, "_be"},   32'(dmem_be_o), 32'(ebe));
    tick();
    dmem_gnt_i    = 1'b0;
    dmem_rvalid_i = 1'b1;
    dmem_rdata_i  = rdata;
    #1;
    chk({tag, "_wait_stall"}, 32'(stall_o), 32'd1);
    tick();
    dmem_rvalid_i = 1'b0;
    dmem_rdata_i  = 32'd0;
    #1;
    waited = 0;
    while (!load_valid_o && waited < 10) begin
      tick();
      waited++;
    end
    chk({tag, "_valid"}, 32'(load_valid_o), 32'd1);
    if (load_valid_o && exp_q.size() > 0) begin
      chk({tag, "_data"}, load_data_o, exp_q.pop_front());
      chk({tag, "_done_stall"}, 32'(stall_o), 32'd0);
    end
    tick();
  endtask

  // Illegal or misaligned access: single-cycle exception, no bus request.
  task automatic do_fault(input string tag, input logic rd, input logic wr,
                          input logic [2:0] f3, input logic [31:0] a, input logic [1:0] ecause);
    drive(rd, wr, f3, a, 32'h1234_5678);
    #1;
    chk({tag, "_exc"},   32'(exc_o), 32'd1);
    chk({tag, "_cause"}, 32'(exc_cause_o), 32'(ecause));
    chk({tag, "_req"},   32'(dmem_req_o), 32'd0);
    chk({tag, "_stall"}, 32'(stall_o), 32'd0);
    tick();
    idle_inputs();
    #1;
    chk({tag, "_after_req"}, 32'(dmem_req_o), 32'd0);
    chk({tag, "_after_exc"}, 32'(exc_o), 32'd0);
  endtask

  initial begin
    rstn = 1'b0;
    idle_inputs();
    dmem_gnt_i    = 1'b0;
    dmem_rvalid_i = 1'b0;
    dmem_rdata_i  = 32'd0;
    tick();
    tick();
    chk("rst_stall", 32'(stall_o), 32'd0);
    chk("rst_req",   32'(dmem_req_o), 32'd0);
    chk("rst_lv",    32'(load_valid_o), 32'd0);
    chk("rst_exc",   32'(exc_o), 32'd0);
    chk("rst_data",  load_data_o, 32'd0);
    rstn = 1'b1;
    tick();

    do_store("sw",       3'b010, 32'h0000_0100, 32'hDEAD_BEEF, 4'b1111, 32'hDEAD_BEEF, 0);
    do_store("sh",       3'b001, 32'h0000_0012, 32'h0000_ABCD, 4'b1100, 32'hABCD_ABCD, 0);
    do_store("sb",       3'b000, 32'h0000_0005, 32'h1234_5677, 4'b0010, 32'h7777_7777, 0);
    do_store("sw_gnt5",  3'b010, 32'h0000_0208, 32'hA5A5_0F0F, 4'b1111, 32'hA5A5_0F0F, 5);

    do_load("lb",  3'b000, 32'h0000_0203, 32'h80FF_FFFF, 4'b1000, 32'hFFFF_FF80);
    do_load("lbu", 3'b100, 32'h0000_0203, 32'h80FF_FFFF, 4'b1000, 32'h0000_0080);
    do_load("lh",  3'b001, 32'h0000_0202, 32'h8001_1234, 4'b1100, 32'hFFFF_8001);
    do_load("lhu", 3'b101, 32'h0000_0000, 32'h1234_F00D, 4'b0011, 32'h0000_F00D);
    do_load("lw",  3'b010, 32'h0000_0300, 32'h1234_5678, 4'b1111, 32'h1234_5678);
    do_load("lb1", 3'b000, 32'h0000_0001, 32'h0000_7F00, 4'b0010, 32'h0000_007F);

    do_fault("lh_mis",   1'b1, 1'b0, 3'b001, 32'h0000_0011, 2'b01);
    do_fault("sw_mis",   1'b0, 1'b1, 3'b010, 32'h0000_0102, 2'b01);
    do_fault("rw_both",  1'b1, 1'b1, 3'b010, 32'h0000_0100, 2'b10);
    do_fault("ld_f3",    1'b1, 1'b0, 3'b011, 32'h0000_0100, 2'b10);
    do_fault("st_f3",    1'b0, 1'b1, 3'b100, 32'h0000_0100, 2'b10);
    chk("hold_data", load_data_o, 32'h0000_007F);

    // Bus timeout: grant never arrives, request stays up for exactly 8 cycles.
    drive(1'b1, 1'b0, 3'b010, 32'h0000_0400, 32'd0);
    tick();
    idle_inputs();
    for (int i = 0; i < 8; i++) begin
      #1;
      chk("to_req", 32'(dmem_req_o), 32'd1);
      tick();
    end
    #1;
    chk("to_req_drop", 32'(dmem_req_o), 32'd0);
    chk("to_exc",      32'(exc_o), 32'd1);
    chk("to_cause",    32'(exc_cause_o), 32'd3);
    chk("to_lv",       32'(load_valid_o), 32'd0);
    chk("to_stall",    32'(stall_o), 32'd0);
    tick();
    #1;
    chk("to_after_exc", 32'(exc_o), 32'd0);

    // Reset while a load waits for rvalid; a late rvalid must be ignored.
    drive(1'b1, 1'b0, 3'b010, 32'h0000_0500, 32'd0);
    tick();
    idle_inputs();
    dmem_gnt_i = 1'b1;
    tick();
    dmem_gnt_i = 1'b0;
    rstn = 1'b0;
    #1;
    chk("rw_wait_stall", 32'(stall_o), 32'd1);
    tick();
    rstn = 1'b1;
    #1;
    chk("rw_stall", 32'(stall_o), 32'd0);
    chk("rw_req",   32'(dmem_req_o), 32'd0);
    chk("rw_exc",   32'(exc_o), 32'd0);
    chk("rw_data",  load_data_o, 32'd0);
    dmem_rvalid_i = 1'b1;
    dmem_rdata_i  = 32'hCAFE_BABE;
    tick();
    dmem_rvalid_i = 1'b0;
    #1;
    chk("rw_late_lv",   32'(load_valid_o), 32'd0);
    chk("rw_late_data", load_data_o, 32'd0);
    tick();
    chk("rw_late_lv2",  32'(load_valid_o), 32'd0);

    // A normal access still works after the aborted one.
    do_load("lw_post", 3'b010, 32'h0000_0604, 32'h0BAD_F00D, 4'b1111, 32'h0BAD_F00D);

    chk("sb_empty", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
